// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared states, opcode/funct constants and ALU codes for the multicycle controller
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // aluop encodings shared between the FSM and the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mc_aludec.sv
// rtl/mc_aludec.sv - ALU control decode from aluop and the R-type funct field
module mc_aludec
    import mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:   alucontrol = ALU_ADD;
                    F_SUB:   alucontrol = ALU_SUB;
                    F_AND:   alucontrol = ALU_AND;
                    F_OR:    alucontrol = ALU_OR;
                    F_SLT:   alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle main control FSM driving memory, register strobes and ALU selects
module mc_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    state_t     state_q;
    logic       pcwrite, branch, memwrite_d, irwrite_d, regwrite_d;
    logic [1:0] aluop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            case (state_q)
                FETCH:  state_q <= DECODE;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state_q <= MEMADR;
                        OP_RTYPE:     state_q <= EXECUTE;
                        OP_BEQ:       state_q <= BRANCH;
                        OP_ADDI:      state_q <= ADDIEXEC;
                        OP_J:         state_q <= JUMP;
                        default:      state_q <= FETCH;
                    endcase
                end
                MEMADR:   state_q <= (op == OP_SW) ? MEMWRITE : MEMREAD;
                MEMREAD:  state_q <= MEMWB;
                EXECUTE:  state_q <= ALUWB;
                ADDIEXEC: state_q <= ADDIWB;
                default:  state_q <= FETCH;
            endcase
        end
    end

    always_comb begin
        pcwrite    = 1'b0;
        branch     = 1'b0;
        memwrite_d = 1'b0;
        irwrite_d  = 1'b0;
        regwrite_d = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = ALUOP_ADD;
        case (state_q)
            FETCH: begin
                alusrcb   = 2'b01;
                irwrite_d = 1'b1;
                pcwrite   = 1'b1;
            end
            DECODE:   alusrcb = 2'b11;
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMREAD:  iord = 1'b1;
            MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_d = 1'b1;
            end
            MEMWRITE: begin
                iord       = 1'b1;
                memwrite_d = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                regdst     = 1'b1;
                regwrite_d = 1'b1;
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB:   regwrite_d = 1'b1;
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset gates every architectural write in the same cycle so an aborted instruction commits nothing
    assign pcen     = ~reset & (pcwrite | (branch & zero));
    assign memwrite = ~reset & memwrite_d;
    assign irwrite  = ~reset & irwrite_d;
    assign regwrite = ~reset & regwrite_d;
    assign state    = state_q;

    mc_aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - scoreboard bench comparing the controller against a per-instruction path model
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'b100011;
    logic [5:0] funct = 6'b100000;
    logic       zero = 1'b0;
    logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          st;
        logic [14:0] outs;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .state      (state)
    );

    function automatic logic [2:0] alu_ref(input logic [1:0] aop, input logic [5:0] f);
        if (aop == 2'b01) return 3'b110;
        if (aop != 2'b10) return 3'b010;
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Output table indexed by state number 0..11 in listed order
    function automatic logic [14:0] model(input int st, input logic [5:0] f, input logic z, input logic rst);
        logic       io = 0, mtr = 0, rd = 0, asa = 0, irw = 0, rw = 0, mw = 0, pcw = 0, br = 0, pce;
        logic [1:0] asb = 0, ps = 0, aop = 0;
        case (st)
            0:  begin asb = 2'b01; irw = 1; pcw = 1; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  io = 1;
            4:  begin mtr = 1; rw = 1; end
            5:  begin io = 1; mw = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8:  begin asa = 1; aop = 2'b01; ps = 2'b01; br = 1; end
            9:  begin asa = 1; asb = 2'b10; end
            10: rw = 1;
            11: begin ps = 2'b10; pcw = 1; end
            default: ;
        endcase
        pce = (pcw | (br & z)) & ~rst;
        mw  = mw & ~rst;
        irw = irw & ~rst;
        rw  = rw & ~rst;
        return {pce, mw, irw, rw, io, mtr, rd, asa, asb, ps, alu_ref(aop, f)};
    endfunction

    function automatic int path_len(input logic [5:0] o);
        case (o)
            6'b100011: return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000010: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int path_at(input logic [5:0] o, input int k);
        int lw_p[5] = '{0, 1, 2, 3, 4};
        int sw_p[4] = '{0, 1, 2, 5};
        int r_p[4]  = '{0, 1, 6, 7};
        int ad_p[4] = '{0, 1, 9, 10};
        int bq_p[3] = '{0, 1, 8};
        int j_p[3]  = '{0, 1, 11};
        case (o)
            6'b100011: return lw_p[k];
            6'b101011: return sw_p[k];
            6'b000000: return r_p[k];
            6'b001000: return ad_p[k];
            6'b000100: return bq_p[k];
            6'b000010: return j_p[k];
            default:   return k;
        endcase
    endfunction

    task automatic push_exp(input int st);
        exp_t e;
        e.st   = st;
        e.outs = model(st, funct, zero, reset);
        q.push_back(e);
    endtask

    // zmode: 0 = zero low, 1 = zero high, 2 = random each cycle; abort_k = cycle index to assert reset (-1 none)
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode, input int abort_k);
        int n;
        n = path_len(o);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            op    = o;
            funct = f;
            zero  = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            reset = (k == abort_k);
            push_exp(path_at(o, k));
            if (k == abort_k) break;
        end
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [14:0] got;
        if (q.size() > 0) begin
            e   = q.pop_front();
            got = {pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
                   alusrcb, pcsrc, alucontrol};
            vectors++;
            if (state !== 4'(e.st)) begin
                miscompares++;
                $display("FAIL state @%0t: got %0d expected %0d", $time, state, e.st);
            end
            vectors++;
            if (got !== e.outs) begin
                miscompares++;
                $display("FAIL outputs st=%0d @%0t: got %b expected %b (pcen,mw,irw,rw,iord,mtr,rdst,asa,asb,pcsrc,aluctl)",
                         e.st, $time, got, e.outs);
            end
        end
    end

    initial begin
        logic [5:0] legal[6];
        logic [5:0] functs[5];
        logic [5:0] o, f;
        int         n, ab;
        legal  = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        // Two reset cycles with lw on op
        repeat (2) begin
            @(posedge clk);
            #1;
            reset = 1'b1;
            push_exp(0);
        end

        run_instr(6'b001000, 6'b000000, 2, -1);
        run_instr(6'b100011, 6'b000000, 2, -1);
        run_instr(6'b101011, 6'b000000, 2, -1);
        run_instr(6'b000000, 6'b101010, 2, -1);
        run_instr(6'b000000, 6'b100010, 2, -1);
        run_instr(6'b000000, 6'b111111, 2, -1);
        run_instr(6'b000100, 6'b000000, 1, -1);
        run_instr(6'b000100, 6'b000000, 0, -1);
        run_instr(6'b000010, 6'b000000, 2, -1);
        run_instr(6'b111111, 6'b000000, 2, -1);
        run_instr(6'b101011, 6'b000000, 2, 3);
        run_instr(6'b000000, 6'b100100, 2, -1);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 6) == 0) begin
                do o = 6'($urandom); while (o inside {legal});
            end else begin
                o = legal[$urandom_range(0, 5)];
            end
            f  = ($urandom_range(0, 5) == 5) ? 6'($urandom) : functs[$urandom_range(0, 4)];
            n  = path_len(o);
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            run_instr(o, f, 2, ab);
        end

        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
